// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the serial-to-parallel frame receiver.
package sipo_rx_pkg;

    // Receiver framing state: waiting for a start-marked bit, or assembling a word.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

    // Bit counter width. The counter never exceeds N-1, so $clog2(N) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_frame_rx_hold_reg.sv
// One-entry valid/ready holding register for assembled words.
// A load that finds the slot occupied and not draining is dropped and reported.
module rx_hold_reg #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         m_ready,
    output logic [N-1:0] m_data,
    output logic         m_valid,
    output logic         drop
);

    logic accept_c;
    logic drain_c;

    // Slot can take a new word when empty or being consumed this cycle.
    always_comb begin
        drain_c  = m_valid && m_ready;
        accept_c = load && (!m_valid || m_ready);
    end

    // Holding register update plus registered drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            drop    <= 1'b0;
        end else begin
            drop <= load && m_valid && !m_ready;
            if (accept_c) begin
                m_data  <= load_data;
                m_valid <= 1'b1;
            end else if (drain_c) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: assembles start-marked serial frames into
// N-bit words and hands them off through a one-word valid/ready holding register.
module sipo_frame_rx
    import sipo_rx_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    input  logic         s_data,
    input  logic         s_start,
    output logic [N-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         busy,
    output logic         overflow,
    output logic         frame_err
);

    localparam int unsigned     CNT_W    = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    rx_state_e        state;
    logic [N-1:0]     shreg;
    logic [CNT_W-1:0] bit_cnt;

    logic [N-1:0]     shift_c;
    logic [N-1:0]     first_c;
    logic             start_c;
    logic             abort_c;
    logic             done_c;

    // Insert one received bit at the end selected by bit order.
    function automatic logic [N-1:0] insert_bit(input logic [N-1:0] base, input logic b);
        if (MSB_FIRST) begin
            return {base[N-2:0], b};
        end else begin
            return {b, base[N-1:1]};
        end
    endfunction

    // Next shift-register images and framing events for the current bit.
    always_comb begin
        shift_c = insert_bit(shreg, s_data);
        first_c = insert_bit({N{1'b0}}, s_data);
        start_c = s_valid && s_start;
        abort_c = (state == SHIFT) && start_c;
        done_c  = (state == SHIFT) && s_valid && !s_start && (bit_cnt == LAST_CNT);
    end

    // Framing FSM, shift register and bit counter with registered busy/frame_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
        end else begin
            frame_err <= abort_c;
            case (state)
                IDLE: begin
                    // Unmarked bits outside a frame are discarded silently.
                    if (start_c) begin
                        shreg   <= first_c;
                        bit_cnt <= ONE_CNT;
                        state   <= SHIFT;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (start_c) begin
                        // New frame restarts assembly; partial word is lost.
                        shreg   <= first_c;
                        bit_cnt <= ONE_CNT;
                    end else if (s_valid) begin
                        if (bit_cnt == LAST_CNT) begin
                            shreg   <= '0;
                            bit_cnt <= '0;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            shreg   <= shift_c;
                            bit_cnt <= bit_cnt + ONE_CNT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Completed word (including the Nth bit) goes straight to the holding register.
    rx_hold_reg #(
        .N(N)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (done_c),
        .load_data(shift_c),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .drop     (overflow)
    );

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx: one MSB-first and one LSB-first instance
// share the same serial stimulus and consumer ready.
module tb_sipo_frame_rx;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_data;
    logic       s_start;
    logic       m_ready;

    logic [7:0] m_data_m, m_data_l;
    logic       m_valid_m, m_valid_l;
    logic       busy_m, busy_l;
    logic       ovf_m, ovf_l;
    logic       ferr_m, ferr_l;

    int         checks = 0;
    int         errors = 0;

    logic [7:0] rx_q[$];
    int         ovf_seen;

    sipo_frame_rx #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_start(s_start),
        .m_data(m_data_m), .m_valid(m_valid_m), .m_ready(m_ready),
        .busy(busy_m), .overflow(ovf_m), .frame_err(ferr_m)
    );

    sipo_frame_rx #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_start(s_start),
        .m_data(m_data_l), .m_valid(m_valid_l), .m_ready(m_ready),
        .busy(busy_l), .overflow(ovf_l), .frame_err(ferr_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record accepted words and overflow pulses of the MSB-first instance.
    always @(posedge clk) begin
        if (!rst && m_valid_m && m_ready) rx_q.push_back(m_data_m);
        if (!rst && ovf_m) ovf_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        s_valid = 1'b1;
        s_data  = b;
        s_start = st;
        tick();
        s_valid = 1'b0;
        s_start = 1'b0;
        s_data  = 1'b0;
    endtask

    // Send bits w[7] down to w[stop_at], start-marking w[7] when st is set.
    task automatic send_bits(input logic [7:0] w, input logic st, input int stop_at);
        for (int i = 7; i >= stop_at; i--) send_bit(w[i], st && (i == 7));
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = 1'b0; s_start = 1'b0; m_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (m_data_m !== 8'h00 || m_data_l !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h/%h exp 00", m_data_m, m_data_l); end
        checks++; if ({m_valid_m, busy_m, ovf_m, ferr_m} !== 4'b0) begin errors++; $display("FAIL reset_flags_msb: got %b exp 0000", {m_valid_m, busy_m, ovf_m, ferr_m}); end
        checks++; if ({m_valid_l, busy_l, ovf_l, ferr_l} !== 4'b0) begin errors++; $display("FAIL reset_flags_lsb: got %b exp 0000", {m_valid_l, busy_l, ovf_l, ferr_l}); end
    endtask

    // Bits 1,0,1,0,0,1,0,1 give 0xA5 in both bit orders.
    task automatic test_basic_word();
        m_ready = 1'b1;
        send_bits(8'hA5, 1'b1, 1);
        checks++; if (m_valid_m !== 1'b0 || busy_m !== 1'b1) begin errors++; $display("FAIL basic_pre_last: got valid=%b busy=%b exp valid=0 busy=1", m_valid_m, busy_m); end
        send_bit(1'b1, 1'b0);
        checks++; if (m_valid_m !== 1'b1 || m_data_m !== 8'hA5) begin errors++; $display("FAIL basic_msb_word: got %b/%h exp 1/a5", m_valid_m, m_data_m); end
        checks++; if (m_valid_l !== 1'b1 || m_data_l !== 8'hA5) begin errors++; $display("FAIL basic_lsb_word: got %b/%h exp 1/a5", m_valid_l, m_data_l); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b exp 0", busy_m); end
        tick();
        checks++; if (m_valid_m !== 1'b0 || m_valid_l !== 1'b0) begin errors++; $display("FAIL basic_valid_clear: got %b/%b exp 0/0", m_valid_m, m_valid_l); end
    endtask

    // Asymmetric pattern: bits 0,0,0,1,0,0,1,0 -> 0x12 MSB-first, 0x48 LSB-first.
    task automatic test_bit_order();
        m_ready = 1'b1;
        send_bits(8'h12, 1'b1, 0);
        checks++; if (m_data_m !== 8'h12) begin errors++; $display("FAIL order_msb: got %h exp 12", m_data_m); end
        checks++; if (m_data_l !== 8'h48) begin errors++; $display("FAIL order_lsb: got %h exp 48", m_data_l); end
        tick();
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        send_bits(8'h3C, 1'b1, 0);
        checks++; if (m_valid_m !== 1'b1 || m_data_m !== 8'h3C) begin errors++; $display("FAIL ovf_first_word: got %b/%h exp 1/3c", m_valid_m, m_data_m); end
        send_bits(8'h81, 1'b1, 1);
        checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b exp 0", ovf_m); end
        send_bit(1'b1, 1'b0);
        checks++; if (ovf_m !== 1'b1 || ovf_l !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b/%b exp 1/1", ovf_m, ovf_l); end
        checks++; if (m_valid_m !== 1'b1 || m_data_m !== 8'h3C) begin errors++; $display("FAIL ovf_held: got %b/%h exp 1/3c", m_valid_m, m_data_m); end
        tick();
        checks++; if (ovf_m !== 1'b0 || m_data_m !== 8'h3C) begin errors++; $display("FAIL ovf_one_cycle: got ovf=%b data=%h exp 0/3c", ovf_m, m_data_m); end
        // Completion coinciding with consumption replaces the word without a bubble.
        send_bits(8'h44, 1'b1, 1);
        m_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        checks++; if (m_valid_m !== 1'b1 || m_data_m !== 8'h44 || ovf_m !== 1'b0) begin errors++; $display("FAIL swap_word: got %b/%h ovf=%b exp 1/44 ovf=0", m_valid_m, m_data_m, ovf_m); end
        tick();
        checks++; if (m_valid_m !== 1'b0) begin errors++; $display("FAIL swap_drain: got %b exp 0", m_valid_m); end
    endtask

    task automatic test_frame_err();
        int pulses;
        pulses  = 0;
        m_ready = 1'b1;
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        checks++; if (busy_m !== 1'b1 || ferr_m !== 1'b0) begin errors++; $display("FAIL ferr_partial: got busy=%b ferr=%b exp 1/0", busy_m, ferr_m); end
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'(8'h5A >> i), i == 7);
            if (ferr_m) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d exp 1", pulses); end
        checks++; if (m_valid_m !== 1'b1 || m_data_m !== 8'h5A || m_data_l !== 8'h5A) begin errors++; $display("FAIL ferr_word: got %b/%h/%h exp 1/5a/5a", m_valid_m, m_data_m, m_data_l); end
        checks++; if (busy_m !== 1'b0 || busy_l !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b/%b exp 0/0", busy_m, busy_l); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        m_ready = 1'b1;
        rx_q.delete();
        ovf_seen = 0;
        for (int f = 0; f < 2; f++) begin
            w = (f == 0) ? 8'h11 : 8'h22;
            for (int i = 7; i >= 0; i--) begin
                send_bit(w[i], i == 7);
                if (i != 0) repeat ($urandom_range(0, 2)) tick();
            end
        end
        tick(); tick();
        checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d exp 2", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22) begin errors++; $display("FAIL b2b_order: got %h,%h exp 11,22", rx_q[0], rx_q[1]); end
        end
        checks++; if (ovf_seen !== 0) begin errors++; $display("FAIL b2b_overflow: got %0d exp 0", ovf_seen); end
    endtask

    task automatic test_mid_frame_reset();
        m_ready = 1'b0;
        send_bits(8'h77, 1'b1, 0);
        send_bits(8'hF0, 1'b1, 3);
        checks++; if (m_valid_m !== 1'b1 || busy_m !== 1'b1) begin errors++; $display("FAIL rst_setup: got valid=%b busy=%b exp 1/1", m_valid_m, busy_m); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({m_valid_m, busy_m, ovf_m, ferr_m} !== 4'b0 || m_data_m !== 8'h00) begin errors++; $display("FAIL rst_mid_msb: got %b data=%h exp 0000/00", {m_valid_m, busy_m, ovf_m, ferr_m}, m_data_m); end
        checks++; if ({m_valid_l, busy_l, ovf_l, ferr_l} !== 4'b0 || m_data_l !== 8'h00) begin errors++; $display("FAIL rst_mid_lsb: got %b data=%h exp 0000/00", {m_valid_l, busy_l, ovf_l, ferr_l}, m_data_l); end
        send_bits(8'hFF, 1'b0, 0);
        tick();
        checks++; if (m_valid_m !== 1'b0 || busy_m !== 1'b0 || ovf_m !== 1'b0) begin errors++; $display("FAIL unmarked_ignored: got valid=%b busy=%b ovf=%b exp 0/0/0", m_valid_m, busy_m, ovf_m); end
        m_ready = 1'b1;
        send_bits(8'h0F, 1'b1, 0);
        checks++; if (m_data_m !== 8'h0F || m_data_l !== 8'hF0 || m_valid_m !== 1'b1) begin errors++; $display("FAIL post_rst_word: got %h/%h v=%b exp 0f/f0 v=1", m_data_m, m_data_l, m_valid_m); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_bit_order();
        test_overflow();
        test_frame_err();
        test_back_to_back();
        test_mid_frame_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
